// File: rtl/column_renderer.sv
// Per-column wall renderer behind the VGA timing generator: double-buffered descriptor RAM,
// swapped at the vsync falling edge, with a 2-stage pixel pipeline and aligned sync outputs.
module column_renderer #(
  parameter int unsigned COLS      = 320,
  parameter int unsigned HORIZON   = 240,
  parameter int unsigned VMAX      = 480,
  parameter logic [11:0] CEIL_RGB  = 12'h333,
  parameter logic [11:0] FLOOR_RGB = 12'h666
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_en,
  input  logic [8:0]  wr_col,
  input  logic [8:0]  wr_height,
  input  logic [11:0] wr_color,
  input  logic        wr_dark,
  output logic        wr_ready,
  input  logic        frame_done,
  output logic        swap_ack,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [9:0]  VMaxW    = 10'(VMAX);
  localparam logic [9:0]  HorizonW = 10'(HORIZON);
  localparam logic [9:0]  ColsW    = 10'(COLS);
  localparam logic [10:0] PixColsW = 11'(2 * COLS);

  // Entry layout: {height[8:0], color[11:0], dark}; address is {bank, column}.
  logic [21:0] ram [1024];
  logic [21:0] rd_data_q;

  logic        front_bank_q, front_bank_d;
  logic        swap_pending_q, swap_pending_d;
  logic        swap_ack_q, swap_ack_d;

  logic [9:0]  v_p1_q, v_p1_d;
  logic        valid_p1_q, valid_p1_d;
  logic        hsync_p1_q, hsync_p1_d;
  logic        vsync_p1_q, vsync_p1_d;

  logic [11:0] rgb_q, rgb_d;
  logic        hsync_p2_q, hsync_p2_d;
  logic        vsync_p2_q, vsync_p2_d;

  logic        wr_fire;
  logic        swap_event;

  logic [8:0]  rd_height;
  logic [11:0] rd_color;
  logic        rd_dark;
  logic [9:0]  hgt_ext;
  logic [9:0]  hgt_clamp;
  logic [9:0]  wall_top;
  logic [9:0]  wall_bot;
  logic [11:0] wall_rgb;

  assign wr_ready   = ~swap_pending_q;
  assign wr_fire    = wr_en & ~swap_pending_q & ({1'b0, wr_col} < ColsW);
  assign swap_event = vsync_p1_q & ~vsync_in;

  always_comb begin
    front_bank_d   = front_bank_q;
    swap_pending_d = swap_pending_q;
    swap_ack_d     = 1'b0;
    if (swap_event && swap_pending_q) begin
      front_bank_d   = ~front_bank_q;
      swap_pending_d = 1'b0;
      swap_ack_d     = 1'b1;
    end else if (frame_done) begin
      swap_pending_d = 1'b1;
    end
  end

  always_comb begin
    v_p1_d     = v_cnt;
    // Off-screen columns are blanked here so stage 2 only needs one qualifier.
    valid_p1_d = valid & ({1'b0, h_cnt} < PixColsW);
    hsync_p1_d = hsync_in;
    vsync_p1_d = vsync_in;
  end

  always_ff @(posedge pclk) begin
    if (wr_fire) begin
      ram[{~front_bank_q, wr_col}] <= {wr_height, wr_color, wr_dark};
    end
    rd_data_q <= ram[{front_bank_q, h_cnt[9:1]}];
  end

  always_comb begin
    rd_height = rd_data_q[21:13];
    rd_color  = rd_data_q[12:1];
    rd_dark   = rd_data_q[0];
    hgt_ext   = {1'b0, rd_height};
    hgt_clamp = (hgt_ext > VMaxW) ? VMaxW : hgt_ext;
    wall_top  = HorizonW - {1'b0, hgt_clamp[9:1]};
    wall_bot  = wall_top + hgt_clamp;
    if (rd_dark) begin
      wall_rgb = {1'b0, rd_color[11:9], 1'b0, rd_color[7:5], 1'b0, rd_color[3:1]};
    end else begin
      wall_rgb = rd_color;
    end
  end

  always_comb begin
    rgb_d      = 12'h000;
    hsync_p2_d = hsync_p1_q;
    vsync_p2_d = vsync_p1_q;
    if (valid_p1_q) begin
      if (v_p1_q < wall_top) begin
        rgb_d = CEIL_RGB;
      end else if (v_p1_q < wall_bot) begin
        rgb_d = wall_rgb;
      end else begin
        rgb_d = FLOOR_RGB;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      front_bank_q   <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_ack_q     <= 1'b0;
      v_p1_q         <= 10'd0;
      valid_p1_q     <= 1'b0;
      hsync_p1_q     <= 1'b1;
      vsync_p1_q     <= 1'b1;
      rgb_q          <= 12'h000;
      hsync_p2_q     <= 1'b1;
      vsync_p2_q     <= 1'b1;
    end else begin
      front_bank_q   <= front_bank_d;
      swap_pending_q <= swap_pending_d;
      swap_ack_q     <= swap_ack_d;
      v_p1_q         <= v_p1_d;
      valid_p1_q     <= valid_p1_d;
      hsync_p1_q     <= hsync_p1_d;
      vsync_p1_q     <= vsync_p1_d;
      rgb_q          <= rgb_d;
      hsync_p2_q     <= hsync_p2_d;
      vsync_p2_q     <= vsync_p2_d;
    end
  end

  assign swap_ack  = swap_ack_q;
  assign rgb       = rgb_q;
  assign hsync_out = hsync_p2_q;
  assign vsync_out = vsync_p2_q;

endmodule
